conv_encoder_frame: RTL and testbench
=====================================

# conv_encoder_frame

Rate-1/2, constraint-length-3 convolutional encoder (generators G0 = 111, G1 = 101) that sits directly upstream of `Viterbi_decoding`. It accepts one parallel frame of FRAME_LEN information bits through a valid/ready handshake and serializes it MSB first. It emits one 2-bit coded symbol per clock on a valid-only stream (`o_data`, `o_valid`) that connects straight to the decoder's `i_data`/`i_valid`. It optionally appends K-1 = 2 zero tail bits so the trellis terminates in state 00.

## Interface
- FRAME_LEN, 8: information bits per frame; legal range ≥ 2.
- TAIL_EN, 1: 1 appends two tail symbols (zero input bits); 0 emits none.

- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_valid  in  1  frame offered on `i_data`.
- i_data  in  FRAME_LEN  frame; bit FRAME_LEN-1 is encoded first.
- o_ready  out  1  block can accept a frame this cycle.
- o_data  out  2  coded symbol {g0, g1}; g0 = b^s1^s2, g1 = b^s2.
- o_valid  out  1  `o_data` holds a symbol this cycle.
- o_last  out  1  marks the final symbol of the frame (tail included when TAIL_EN = 1).

## Operation
- States:
  - IDLE: accepting a frame.
  - DATA: emitting information symbols.
  - TAIL: emitting tail symbols. TAIL is unreachable when TAIL_EN = 0.
- `o_ready` = (state == IDLE), decoded combinationally from the state register.
- A frame is accepted on a rising edge where `i_valid && o_ready`. `i_data` is sampled only on that edge; the bench need not hold it afterwards.
- On acceptance:
  - Load the shift buffer with `i_data`.
  - Clear the encoder memory (s1, s2) to 00; every frame starts from trellis state 00.
  - Register the first symbol into `o_data` and set `o_valid` = 1 on the same edge.
  - Set bit count = 1 and go to DATA.
- Each following edge in DATA:
  - Encode the next bit b using the current s1, s2.
  - Update s2 ← s1, s1 ← b.
  - Increment the count.
- After the FRAME_LEN-th information symbol is registered:
  - TAIL_EN = 1: go to TAIL and emit two symbols with b = 0.
  - TAIL_EN = 0: that symbol is the last one.
- On the edge that registers the last symbol:
  - Set `o_last` = 1.
  - Set state ← IDLE, so `o_ready` is high during the last-symbol cycle.
- On a new acceptance during the last-symbol cycle, the next frame's first symbol follows with no bubble.
- With no acceptance, `o_valid`, `o_last` and `o_data` return to 0 on the next edge.
- There is no backpressure on the output side. One symbol per cycle is guaranteed while the state is not IDLE.
- `i_valid` while `o_ready` = 0 is ignored; no frame is queued.
- Counter width is $clog2(FRAME_LEN+2). The count saturates at its terminal value and never wraps.

## Timing
- Reset values: state IDLE, `o_ready` 1, `o_valid` 0, `o_last` 0, `o_data` 00, s1 s2 00, count 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). Outputs take their reset values. No partial symbols are emitted after release.
- Latency: the first symbol is visible in the cycle after the acceptance edge.
- Burst length: `o_valid` stays high for exactly FRAME_LEN + 2·TAIL_EN consecutive cycles.
- `o_last` is high for exactly one cycle, coincident with the final `o_valid`.
- `o_ready` is low from the acceptance edge until the edge that registers the last symbol.

## Structure
- Shared package `viterbi_pkg` holds:
  - localparam K = 3, G0 = 3'b111, G1 = 3'b101;
  - enum `enc_state_t` {IDLE, DATA, TAIL};
  - function `conv_encode(b, s1, s2)` returning the 2-bit symbol. `Viterbi_decoding` reuses the same generators for its branch metrics.
- No sub-module: a single FSM plus datapath (shift buffer, two memory flops, counter, output registers).

## Test plan
- TAIL_EN = 0, frame 8'b11011010 → symbols 11 01 01 00 01 01 00 10; `o_last` on the 8th; `o_ready` low for 7 cycles.
- TAIL_EN = 1, frame 8'b10101010 → 11 10 00 10 00 10 00 10 then tail 11 00; `o_last` on the 10th symbol only.
- TAIL_EN = 1, frame 8'b00000001 → seven 00 symbols, then 11, then tail 10 11.
- Back-to-back: 8'b11011010 then 8'b00000001, with `i_valid` held high → 20 contiguous `o_valid` cycles. The second frame starts at 00, proving the memory clears at each frame.
- Reset mid-frame: assert `i_rst_n` = 0 after the 4th symbol of frame 1 → `o_valid`/`o_data` go to 0 asynchronously and `o_ready` = 1. A fresh 8'b10101010 then encodes exactly as in scenario 2.
- Ignored input: pulse `i_valid` with 8'hFF while busy → the current frame's output is unchanged and no extra symbols appear afterwards.
- Loopback: feed `o_data`/`o_valid` into `Viterbi_decoding` → decoded bits equal the source frame for all three vectors above.

Source files
------------

// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Definitions shared by the convolutional encoder and the Viterbi decoder.
// The code is rate 1/2 with constraint length 3.
//
// Contents
//   K, G0, G1     constraint length and generator polynomials
//                 G0 = 111 -> g0 = b ^ s1 ^ s2
//                 G1 = 101 -> g1 = b ^ s2
//   enc_state_t   encoder FSM states
//   conv_encode   one trellis step; returns the symbol {g0, g1}
// ---------------------------------------------------------------------------
package viterbi_pkg;

    localparam int         K  = 3;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    // The tap vector is ordered {newest bit, s1, s2}, which matches the
    // generator bit order. Each output is the parity of the taps its
    // generator selects.
    function automatic logic [1:0] conv_encode(input logic b, input logic s1, input logic s2);
        logic [2:0] w_taps;
        w_taps = {b, s1, s2};
        return {^(w_taps & G0), ^(w_taps & G1)};
    endfunction

endpackage

// File: rtl/conv_encoder_frame_if.sv
// ---------------------------------------------------------------------------
// conv_encoder_frame_if
// Bundles the signals between the encoder and the blocks on either side of it.
//
// Input side (valid/ready):
//   i_valid  a frame is offered on i_data
//   i_data   parallel frame; bit FRAME_LEN-1 is encoded first
//   o_ready  the encoder can accept a frame this cycle
// Output side (valid only, no backpressure):
//   o_data   coded symbol {g0, g1}
//   o_valid  o_data holds a symbol this cycle
//   o_last   marks the final symbol of the frame
//
// Modports
//   master   frame source and symbol sink (testbench or upstream logic)
//   slave    the encoder
// ---------------------------------------------------------------------------
interface conv_encoder_frame_if #(
    parameter int FRAME_LEN = 8
);

    logic                 i_valid;
    logic [FRAME_LEN-1:0] i_data;
    logic                 o_ready;
    logic [1:0]           o_data;
    logic                 o_valid;
    logic                 o_last;

    modport master (
        output i_valid,
        output i_data,
        input  o_ready,
        input  o_data,
        input  o_valid,
        input  o_last
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_ready,
        output o_data,
        output o_valid,
        output o_last
    );

endinterface

// File: rtl/conv_encoder_frame.sv
// ---------------------------------------------------------------------------
// conv_encoder_frame
// Frame-based rate-1/2, K=3 convolutional encoder (G0 = 111, G1 = 101).
// A parallel frame is accepted through a valid/ready handshake and encoded
// MSB first, one 2-bit symbol per clock. When TAIL_EN is 1, two zero tail
// bits are appended so that the trellis ends in state 00.
//
// Parameters
//   FRAME_LEN  information bits per frame (>= 2)
//   TAIL_EN    1 appends two tail symbols, 0 appends none
// Ports
//   i_clk      clock; all logic runs on the rising edge
//   i_rst_n    asynchronous active-low reset
//   bus        conv_encoder_frame_if.slave (i_valid/i_data/o_ready in,
//              o_data/o_valid/o_last out)
// ---------------------------------------------------------------------------
module conv_encoder_frame
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter bit TAIL_EN   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    conv_encoder_frame_if.slave   bus
);

    localparam int             CW        = $clog2(FRAME_LEN + 2);
    localparam logic [CW-1:0]  CNT_DATA  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]  CNT_TAIL  = CW'(FRAME_LEN + 1);
    // FRAME_LEN+1 always fits in CW bits. The counter holds at this value
    // and never wraps.
    localparam logic [CW-1:0]  CNT_TERM  = CW'(FRAME_LEN + 1);

    enc_state_t           r_state;
    logic [FRAME_LEN-1:0] r_shift;
    logic                 r_s1;
    logic                 r_s2;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_data;
    logic                 r_valid;
    logic                 r_last;

    enc_state_t           w_next_state;
    logic [FRAME_LEN-1:0] w_next_shift;
    logic                 w_next_s1;
    logic                 w_next_s2;
    logic [CW-1:0]        w_next_cnt;
    logic [1:0]           w_next_data;
    logic                 w_next_valid;
    logic                 w_next_last;
    logic [CW-1:0]        w_cnt_inc;

    // The counter saturates at its terminal value instead of wrapping.
    assign w_cnt_inc = (r_cnt == CNT_TERM) ? r_cnt : r_cnt + 1'b1;

    // The encoder accepts a frame only in IDLE. The last-symbol edge already
    // moves the state back to IDLE, so the next frame can be accepted in the
    // same cycle that the final symbol is shown, with no gap between frames.
    assign bus.o_ready = (r_state == IDLE);
    assign bus.o_data  = r_data;
    assign bus.o_valid = r_valid;
    assign bus.o_last  = r_last;

    // This block computes the next state and the next datapath values.
    // Each symbol is computed here and registered on the same edge that
    // consumes its bit. On acceptance, the encoder memory is forced to 00,
    // so the first symbol of every frame is simply {b, b}.
    always_comb begin
        w_next_state = r_state;
        w_next_shift = r_shift;
        w_next_s1    = r_s1;
        w_next_s2    = r_s2;
        w_next_cnt   = r_cnt;
        w_next_data  = 2'b00;
        w_next_valid = 1'b0;
        w_next_last  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.i_valid) begin
                    w_next_data  = conv_encode(bus.i_data[FRAME_LEN-1], 1'b0, 1'b0);
                    w_next_s1    = bus.i_data[FRAME_LEN-1];
                    w_next_s2    = 1'b0;
                    w_next_shift = bus.i_data << 1;
                    w_next_cnt   = CW'(1);
                    w_next_valid = 1'b1;
                    w_next_state = DATA;
                end
            end

            DATA: begin
                w_next_data  = conv_encode(r_shift[FRAME_LEN-1], r_s1, r_s2);
                w_next_s1    = r_shift[FRAME_LEN-1];
                w_next_s2    = r_s1;
                w_next_shift = r_shift << 1;
                w_next_cnt   = w_cnt_inc;
                w_next_valid = 1'b1;
                // When r_cnt is FRAME_LEN-1, this edge registers the final
                // information symbol.
                if (r_cnt == CNT_DATA) begin
                    if (TAIL_EN) begin
                        w_next_state = TAIL;
                    end else begin
                        w_next_last  = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end

            TAIL: begin
                w_next_data  = conv_encode(1'b0, r_s1, r_s2);
                w_next_s1    = 1'b0;
                w_next_s2    = r_s1;
                w_next_cnt   = w_cnt_inc;
                w_next_valid = 1'b1;
                // The first tail edge sees FRAME_LEN, and the second sees
                // FRAME_LEN+1.
                if (r_cnt == CNT_TAIL) begin
                    w_next_last  = 1'b1;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // This is the state register. An asynchronous reset aborts any frame
    // that is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // These are the datapath registers: shift buffer, encoder memory,
    // counter and the registered output symbol. Reset clears the outputs
    // immediately, so no partial symbol appears after reset is released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_data  <= 2'b00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_shift <= w_next_shift;
            r_s1    <= w_next_s1;
            r_s2    <= w_next_s2;
            r_cnt   <= w_next_cnt;
            r_data  <= w_next_data;
            r_valid <= w_next_valid;
            r_last  <= w_next_last;
        end
    end

endmodule

// File: tb/tb_conv_encoder_frame.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder_frame
// Testbench for conv_encoder_frame. It builds two encoders, one with
// TAIL_EN = 0 (channel 0) and one with TAIL_EN = 1 (channel 1), and drives
// directed frames into them.
// A frame-level model computes the expected symbol stream from the code
// definition. One compare process checks both encoders against that model
// on every falling edge.
// ---------------------------------------------------------------------------
module tb_conv_encoder_frame;

    typedef struct packed {
        logic [1:0] data;
        logic       last;
    } sym_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   total = 0;
    int   bad   = 0;

    sym_t q0[$];
    sym_t q1[$];
    int   burst[2];
    int   lastBurst[2];
    int   readyLow[2];

    always #5 clk = ~clk;

    conv_encoder_frame_if #(.FRAME_LEN(8)) if0 ();
    conv_encoder_frame_if #(.FRAME_LEN(8)) if1 ();

    conv_encoder_frame #(.FRAME_LEN(8), .TAIL_EN(1'b0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if0)
    );

    conv_encoder_frame #(.FRAME_LEN(8), .TAIL_EN(1'b1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if1)
    );

    // This function is the frame-level reference. It lists the input bits
    // MSB first, adds two zero tail bits if tailEn is set, and encodes each
    // bit against the two bits before it. The encoder starts every frame in
    // state 00. Symbol i is placed at bits [19-2i -: 2].
    function automatic logic [19:0] encodeFrame(input logic [7:0] frame, input bit tailEn);
        logic [9:0]  bits;
        logic [19:0] res;
        int          n;
        logic        p1;
        logic        p2;
        res = '0;
        n   = tailEn ? 10 : 8;
        for (int i = 0; i < 10; i++) bits[i] = (i < 8) ? frame[7-i] : 1'b0;
        for (int i = 0; i < n; i++) begin
            p1 = (i >= 1) ? bits[i-1] : 1'b0;
            p2 = (i >= 2) ? bits[i-2] : 1'b0;
            res[19-2*i -: 2] = {bits[i] ^ p1 ^ p2, bits[i] ^ p2};
        end
        return res;
    endfunction

    // This task compares one value, counts the comparison and reports any
    // difference.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // This task checks one channel for one cycle. If a symbol is shown, it
    // must be the next expected symbol, and o_ready must be high only on the
    // frame's last symbol. If no symbol is shown, the outputs must be idle.
    // The task also tracks burst lengths and the number of cycles with
    // o_ready low.
    task automatic checkOutput(input int ch, input logic v, input logic [1:0] d,
                               input logic l, input logic r);
        sym_t e;
        bit   empty;
        empty = (ch == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (v) begin
            if (empty) begin
                total++;
                bad++;
                $display("[TB] FAIL ch%0d_extra_symbol: got data %b, expected no symbol at %0t", ch, d, $time);
            end else begin
                e = (ch == 0) ? q0.pop_front() : q1.pop_front();
                checkVal($sformatf("ch%0d_data", ch),  32'(d), 32'(e.data));
                checkVal($sformatf("ch%0d_last", ch),  32'(l), 32'(e.last));
                checkVal($sformatf("ch%0d_ready", ch), 32'(r), 32'(e.last));
            end
            burst[ch]++;
        end else begin
            checkVal($sformatf("ch%0d_idle_data", ch),  32'(d), 32'd0);
            checkVal($sformatf("ch%0d_idle_last", ch),  32'(l), 32'd0);
            checkVal($sformatf("ch%0d_idle_ready", ch), 32'(r), 32'd1);
            if (burst[ch] > 0) begin
                lastBurst[ch] = burst[ch];
                burst[ch]     = 0;
            end
        end
        if (!r) readyLow[ch]++;
    endtask

    // This is the single compare process. It samples both encoders on the
    // falling edge, away from the edge where the DUT updates.
    always @(negedge clk) begin
        checkOutput(0, if0.o_valid, if0.o_data, if0.o_last, if0.o_ready);
        checkOutput(1, if1.o_valid, if1.o_data, if1.o_last, if1.o_ready);
    end

    // This task queues the model's symbols for a frame that has just been
    // accepted.
    task automatic expectFrame(input int ch, input logic [7:0] frame);
        logic [19:0] syms;
        int          n;
        sym_t        s;
        syms = encodeFrame(frame, ch == 1);
        n    = (ch == 1) ? 10 : 8;
        for (int i = 0; i < n; i++) begin
            s.data = syms[19-2*i -: 2];
            s.last = (i == n - 1);
            if (ch == 0) q0.push_back(s);
            else         q1.push_back(s);
        end
    endtask

    // This task offers a frame on the given channel and waits, within a
    // fixed cycle budget, for o_ready. It returns just after the acceptance
    // edge. i_valid stays high so that frames can be sent back to back.
    task automatic applyStimulus(input int ch, input logic [7:0] frame);
        bit rdy;
        @(negedge clk);
        if (ch == 0) begin if0.i_valid = 1'b1; if0.i_data = frame; end
        else         begin if1.i_valid = 1'b1; if1.i_data = frame; end
        rdy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rdy = (ch == 0) ? if0.o_ready : if1.o_ready;
            if (rdy) break;
            @(negedge clk);
        end
        if (!rdy) begin
            total++;
            bad++;
            $display("[TB] FAIL ch%0d_accept_timeout: got o_ready 0, expected 1 within 100 cycles", ch);
        end else begin
            expectFrame(ch, frame);
        end
        @(posedge clk);
    endtask

    task automatic dropValid(input int ch);
        #1;
        if (ch == 0) if0.i_valid = 1'b0;
        else         if1.i_valid = 1'b0;
    endtask

    // This task waits, within a bounded time, until every expected symbol
    // has been seen. It then lets the burst counters settle.
    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (q0.size() == 0 && q1.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d/%0d symbols pending, expected 0/0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // This task checks that both encoders show their reset values.
    task automatic checkResetState(input string tag);
        checkVal({tag, "_ch0_ready"}, 32'(if0.o_ready), 32'd1);
        checkVal({tag, "_ch0_valid"}, 32'(if0.o_valid), 32'd0);
        checkVal({tag, "_ch0_last"},  32'(if0.o_last),  32'd0);
        checkVal({tag, "_ch0_data"},  32'(if0.o_data),  32'd0);
        checkVal({tag, "_ch1_ready"}, 32'(if1.o_ready), 32'd1);
        checkVal({tag, "_ch1_valid"}, 32'(if1.o_valid), 32'd0);
        checkVal({tag, "_ch1_last"},  32'(if1.o_last),  32'd0);
        checkVal({tag, "_ch1_data"},  32'(if1.o_data),  32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [19:0] m;

        if0.i_valid = 1'b0; if0.i_data = '0;
        if1.i_valid = 1'b0; if1.i_data = '0;
        for (int c = 0; c < 2; c++) begin
            burst[c] = 0; lastBurst[c] = 0; readyLow[c] = 0;
        end

        // Hand-computed symbol streams that pin the reference model.
        m = encodeFrame(8'b11011010, 1'b0);
        checkVal("model_11011010_notail", 32'(m[19:4]), 32'hD452);
        m = encodeFrame(8'b10101010, 1'b1);
        checkVal("model_10101010_tail", 32'(m), 32'hE222C);
        m = encodeFrame(8'b00000001, 1'b1);
        checkVal("model_00000001_tail", 32'(m), 32'h0003B);

        // Reset state.
        #3;
        checkResetState("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1: TAIL_EN = 0 with frame 11011010.
        readyLow[0] = 0;
        applyStimulus(0, 8'b11011010);
        dropValid(0);
        waitDrain();
        checkVal("s1_burst_len", 32'(lastBurst[0]), 32'd8);
        checkVal("s1_ready_low_cycles", 32'(readyLow[0]), 32'd7);

        // Scenario 2: TAIL_EN = 1 with frame 10101010.
        applyStimulus(1, 8'b10101010);
        dropValid(1);
        waitDrain();
        checkVal("s2_burst_len", 32'(lastBurst[1]), 32'd10);

        // Scenario 3: TAIL_EN = 1 with frame 00000001.
        applyStimulus(1, 8'b00000001);
        dropValid(1);
        waitDrain();
        checkVal("s3_burst_len", 32'(lastBurst[1]), 32'd10);

        // Scenario 4: two frames back to back with i_valid held high. The
        // second frame must start from state 00.
        applyStimulus(1, 8'b11011010);
        applyStimulus(1, 8'b00000001);
        dropValid(1);
        waitDrain();
        checkVal("s4_contiguous_len", 32'(lastBurst[1]), 32'd20);

        // Scenario 5: pulse i_valid with 8'hFF while busy. The pulse must be
        // ignored.
        applyStimulus(1, 8'b10101010);
        dropValid(1);
        repeat (3) @(negedge clk);
        if1.i_valid = 1'b1;
        if1.i_data  = 8'hFF;
        @(negedge clk);
        if1.i_valid = 1'b0;
        waitDrain();
        checkVal("s5_burst_len", 32'(lastBurst[1]), 32'd10);

        // Scenario 6: assert reset after the 4th symbol. The outputs must
        // clear asynchronously, and a fresh frame must then encode cleanly.
        applyStimulus(1, 8'b11011010);
        dropValid(1);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("s6_async_valid", 32'(if1.o_valid), 32'd0);
        checkVal("s6_async_data",  32'(if1.o_data),  32'd0);
        checkVal("s6_async_last",  32'(if1.o_last),  32'd0);
        checkVal("s6_async_ready", 32'(if1.o_ready), 32'd1);
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1, 8'b10101010);
        dropValid(1);
        waitDrain();
        checkVal("s6_after_reset_burst", 32'(lastBurst[1]), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
